// File: rtl/vic_pkg.sv
// Shared constants, register map and FSM encoding for the interrupt source arbiter.
package vic_pkg;

    localparam int unsigned VEC_W   = 5;
    localparam int unsigned MAX_IRQ = 32;
    localparam int unsigned REG_W   = 32;
    localparam int unsigned ADDR_W  = 2;

    localparam logic [ADDR_W-1:0] VIC_REG_MASK    = 2'd0;
    localparam logic [ADDR_W-1:0] VIC_REG_PENDING = 2'd1;
    localparam logic [ADDR_W-1:0] VIC_REG_STATUS  = 2'd2;
    localparam logic [ADDR_W-1:0] VIC_REG_SWTRIG  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_GAP    = 2'd2
    } vic_state_e;

endpackage

// File: rtl/vic_arbiter_if.sv
// Interrupt lines, config bus and controller-facing request signals of the arbiter.
interface vic_arbiter_if #(
    parameter int unsigned NUM_IRQ = 8
);
    logic [NUM_IRQ-1:0]         i_irq_lines;
    logic                       i_reti;
    logic                       i_cfg_we;
    logic [vic_pkg::ADDR_W-1:0] i_cfg_addr;
    logic [vic_pkg::REG_W-1:0]  i_cfg_wdata;
    logic [vic_pkg::REG_W-1:0]  o_cfg_rdata;
    logic                       o_IRQ;
    logic [vic_pkg::VEC_W-1:0]  o_ISR_addr;
    logic                       o_active;

    modport slave (
        input  i_irq_lines, i_reti, i_cfg_we, i_cfg_addr, i_cfg_wdata,
        output o_cfg_rdata, o_IRQ, o_ISR_addr, o_active
    );

    modport master (
        output i_irq_lines, i_reti, i_cfg_we, i_cfg_addr, i_cfg_wdata,
        input  o_cfg_rdata, o_IRQ, o_ISR_addr, o_active
    );
endinterface

// File: rtl/vic_prio_enc.sv
// Fixed-priority encoder: index of the lowest set request bit, bit 0 highest priority.
module vic_prio_enc
    import vic_pkg::*;
#(
    parameter int unsigned NUM_IRQ = 8
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic [VEC_W-1:0]   idx,
    output logic               valid
);

    // Scan high to low so the lowest set index is the last one written.
    always_comb begin
        idx = '0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = VEC_W'(i);
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/vic_arbiter.sv
// Edge-detecting interrupt source arbiter: latches pending sources, applies the
// enable mask and dispatches one source at a time to the vectored controller.
module vic_arbiter
    import vic_pkg::*;
#(
    parameter int unsigned NUM_IRQ = 8
) (
    input logic          clk,
    input logic          rst,
    vic_arbiter_if.slave bus
);

    vic_state_e         state_q, state_d;
    logic               irq_q, irq_d;
    logic               active_q, active_d;
    logic [VEC_W-1:0]   vec_q, vec_d;

    logic [NUM_IRQ-1:0] mask_q;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] lines_prev_q;

    logic [NUM_IRQ-1:0] wdata_n;
    logic [NUM_IRQ-1:0] pend_set, sw_set, w1c_clr, disp_clr, eligible;
    logic               mask_we, pend_we, swtrig_we;
    logic [VEC_W-1:0]   win_idx;
    logic               win_valid;
    logic               unused_wdata;

    assign wdata_n      = bus.i_cfg_wdata[NUM_IRQ-1:0];
    assign unused_wdata = ^bus.i_cfg_wdata;

    assign mask_we   = bus.i_cfg_we && (bus.i_cfg_addr == VIC_REG_MASK);
    assign pend_we   = bus.i_cfg_we && (bus.i_cfg_addr == VIC_REG_PENDING);
    assign swtrig_we = bus.i_cfg_we && (bus.i_cfg_addr == VIC_REG_SWTRIG);

    assign pend_set = bus.i_irq_lines & ~lines_prev_q;
    assign sw_set   = swtrig_we ? wdata_n : '0;
    assign w1c_clr  = pend_we   ? wdata_n : '0;
    assign eligible = pending_q & mask_q;

    vic_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio_enc (
        .req   (eligible),
        .idx   (win_idx),
        .valid (win_valid)
    );

    // Sets are OR-ed in after the clear so a same-cycle set wins.
    assign pending_d = (pending_q & ~(disp_clr | w1c_clr)) | pend_set | sw_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            irq_q        <= 1'b0;
            active_q     <= 1'b0;
            vec_q        <= '0;
            mask_q       <= '0;
            pending_q    <= '0;
            lines_prev_q <= '0;
        end else begin
            state_q      <= state_d;
            irq_q        <= irq_d;
            active_q     <= active_d;
            vec_q        <= vec_d;
            pending_q    <= pending_d;
            lines_prev_q <= bus.i_irq_lines;
            if (mask_we) begin
                mask_q <= wdata_n;
            end
        end
    end

    // Dispatch FSM; GAP forces one low cycle of o_IRQ between requests.
    always_comb begin
        state_d  = state_q;
        irq_d    = irq_q;
        active_d = active_q;
        vec_d    = vec_q;
        disp_clr = '0;
        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    state_d  = ST_ACTIVE;
                    irq_d    = 1'b1;
                    active_d = 1'b1;
                    vec_d    = win_idx;
                    disp_clr = NUM_IRQ'(1) << win_idx;
                end
            end
            ST_ACTIVE: begin
                if (bus.i_reti) begin
                    state_d  = ST_GAP;
                    irq_d    = 1'b0;
                    active_d = 1'b0;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                irq_d    = 1'b0;
                active_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        bus.o_cfg_rdata = '0;
        case (bus.i_cfg_addr)
            VIC_REG_MASK:    bus.o_cfg_rdata = REG_W'(mask_q);
            VIC_REG_PENDING: bus.o_cfg_rdata = REG_W'(pending_q);
            VIC_REG_STATUS:  bus.o_cfg_rdata = {19'd0, vec_q, 7'd0, active_q};
            default:         bus.o_cfg_rdata = '0;
        endcase
    end

    assign bus.o_IRQ      = irq_q;
    assign bus.o_active   = active_q;
    assign bus.o_ISR_addr = vec_q;

endmodule

// File: tb/tb_vic_arbiter.sv
// Directed self-checking bench for vic_arbiter with hand-computed expectations.
module tb_vic_arbiter;
    import vic_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   tests  = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    vic_arbiter_if #(.NUM_IRQ(8)) ifc ();

    vic_arbiter #(.NUM_IRQ(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic rd_check(input string tag, input logic [1:0] addr, input logic [31:0] exp);
        ifc.i_cfg_addr = addr;
        #1;
        check(tag, ifc.o_cfg_rdata, exp);
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [31:0] data);
        ifc.i_cfg_we    = 1'b1;
        ifc.i_cfg_addr  = addr;
        ifc.i_cfg_wdata = data;
        tick();
        ifc.i_cfg_we    = 1'b0;
        ifc.i_cfg_wdata = '0;
    endtask

    task automatic reti_pulse();
        ifc.i_reti = 1'b1;
        tick();
        ifc.i_reti = 1'b0;
    endtask

    task automatic chk_irq(input string tag, input logic irq, input logic [4:0] vec);
        check({tag, "_irq"}, 32'(ifc.o_IRQ), 32'(irq));
        check({tag, "_vec"}, 32'(ifc.o_ISR_addr), 32'(vec));
    endtask

    initial begin
        rst             = 1'b1;
        ifc.i_irq_lines = '0;
        ifc.i_reti      = 1'b0;
        ifc.i_cfg_we    = 1'b0;
        ifc.i_cfg_addr  = '0;
        ifc.i_cfg_wdata = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk_irq("rst", 1'b0, 5'd0);
        check("rst_active", 32'(ifc.o_active), 32'd0);
        rd_check("rst_mask", VIC_REG_MASK, 32'h0);
        rd_check("rst_pend", VIC_REG_PENDING, 32'h0);
        rd_check("rst_status", VIC_REG_STATUS, 32'h0);

        // Basic dispatch of line 3
        cfg_write(VIC_REG_MASK, 32'hFF);
        rd_check("mask_rb", VIC_REG_MASK, 32'hFF);
        ifc.i_irq_lines = 8'h08;
        tick();
        chk_irq("basic_k", 1'b0, 5'd0);
        rd_check("basic_pend_k", VIC_REG_PENDING, 32'h08);
        ifc.i_irq_lines = 8'h00;
        tick();
        chk_irq("basic_k1", 1'b1, 5'd3);
        check("basic_active", 32'(ifc.o_active), 32'd1);
        rd_check("basic_pend_clr", VIC_REG_PENDING, 32'h0);
        rd_check("basic_status", VIC_REG_STATUS, 32'h301);
        reti_pulse();
        chk_irq("basic_ret", 1'b0, 5'd3);
        rd_check("basic_status_ret", VIC_REG_STATUS, 32'h300);
        tick();

        // Priority: lines 5 and 2 together
        ifc.i_irq_lines = 8'h24;
        tick();
        ifc.i_irq_lines = 8'h00;
        tick();
        chk_irq("prio_first", 1'b1, 5'd2);
        rd_check("prio_pend", VIC_REG_PENDING, 32'h20);
        reti_pulse();
        chk_irq("prio_gap1", 1'b0, 5'd2);
        tick();
        chk_irq("prio_gap2", 1'b0, 5'd2);
        tick();
        chk_irq("prio_second", 1'b1, 5'd5);
        reti_pulse();
        tick();

        // Masking
        cfg_write(VIC_REG_MASK, 32'h01);
        ifc.i_irq_lines = 8'h10;
        tick();
        ifc.i_irq_lines = 8'h00;
        tick();
        tick();
        check("mask_noirq", 32'(ifc.o_IRQ), 32'd0);
        rd_check("mask_pend", VIC_REG_PENDING, 32'h10);
        cfg_write(VIC_REG_MASK, 32'h10);
        check("mask_wr_edge", 32'(ifc.o_IRQ), 32'd0);
        tick();
        chk_irq("mask_unmask", 1'b1, 5'd4);
        reti_pulse();
        tick();

        // Level hold on line 1 for 10 cycles: one dispatch only
        cfg_write(VIC_REG_MASK, 32'hFF);
        ifc.i_irq_lines = 8'h02;
        tick();
        tick();
        chk_irq("level_disp", 1'b1, 5'd1);
        reti_pulse();
        for (int i = 0; i < 7; i++) tick();
        check("level_once", 32'(ifc.o_IRQ), 32'd0);
        rd_check("level_pend", VIC_REG_PENDING, 32'h0);
        ifc.i_irq_lines = 8'h00;
        tick();

        // Software trigger
        cfg_write(VIC_REG_SWTRIG, 32'h80);
        check("sw_k", 32'(ifc.o_IRQ), 32'd0);
        rd_check("sw_read0", VIC_REG_SWTRIG, 32'h0);
        tick();
        chk_irq("sw_disp", 1'b1, 5'd7);
        reti_pulse();
        tick();

        // W1C cancels a pending source before dispatch
        cfg_write(VIC_REG_MASK, 32'h00);
        cfg_write(VIC_REG_SWTRIG, 32'h80);
        rd_check("cancel_pend", VIC_REG_PENDING, 32'h80);
        cfg_write(VIC_REG_PENDING, 32'h80);
        rd_check("cancel_clr", VIC_REG_PENDING, 32'h0);
        cfg_write(VIC_REG_MASK, 32'hFF);
        tick();
        tick();
        check("cancel_noirq", 32'(ifc.o_IRQ), 32'd0);

        // Line 0 edge coincides with its own dispatch clear: set wins
        cfg_write(VIC_REG_SWTRIG, 32'h01);
        ifc.i_irq_lines = 8'h01;
        tick();
        chk_irq("coll_disp", 1'b1, 5'd0);
        rd_check("coll_pend", VIC_REG_PENDING, 32'h01);
        ifc.i_irq_lines = 8'h00;
        reti_pulse();
        tick();
        tick();
        chk_irq("coll_redisp", 1'b1, 5'd0);
        rd_check("coll_pend2", VIC_REG_PENDING, 32'h0);

        // Reset during ACTIVE with a pending bit
        ifc.i_irq_lines = 8'h08;
        tick();
        rd_check("rstmid_pend", VIC_REG_PENDING, 32'h08);
        check("rstmid_pre", 32'(ifc.o_IRQ), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_irq("rstmid", 1'b0, 5'd0);
        check("rstmid_active", 32'(ifc.o_active), 32'd0);
        rd_check("rstmid_pend0", VIC_REG_PENDING, 32'h0);
        rd_check("rstmid_mask0", VIC_REG_MASK, 32'h0);
        ifc.i_irq_lines = 8'h00;
        tick();

        // i_reti in IDLE is ignored
        reti_pulse();
        chk_irq("reti_idle", 1'b0, 5'd0);
        rd_check("reti_idle_status", VIC_REG_STATUS, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/vic_arbiter.md
# vic_arbiter

Interrupt source arbiter that sits in front of the vectored interrupt controller. It detects rising edges on up to 32 peripheral interrupt lines and latches them as pending bits. It applies a software enable mask and picks the lowest-numbered enabled pending source. It then presents that source to the controller as a clean rising `o_IRQ` edge plus a 5-bit vector index, and holds off further dispatch until the controller signals return-from-interrupt. There is no nesting.

## Interface
- `NUM_IRQ`, default 8, number of interrupt lines (1..32); line n maps to vector n.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_irq_lines`  in  NUM_IRQ  peripheral interrupt requests, level; only rising edges count.
- `i_reti`  in  1  return-from-interrupt strobe from the pipeline; one cycle high.
- `i_cfg_we`  in  1  config write strobe.
- `i_cfg_addr`  in  2  config register select.
- `i_cfg_wdata`  in  32  config write data.
- `o_cfg_rdata`  out  32  config read data, combinational from `i_cfg_addr`.
- `o_IRQ`  out  1  interrupt request to the controller; high for the whole in-service period.
- `o_ISR_addr`  out  5  vector index of the dispatched source; the controller shifts it left by 4.
- `o_active`  out  1  high while a source is in service.

## Operation
- **Registers.** Unimplemented bits read 0 and ignore writes.
  - 0 MASK: read/write, reset 0, meaning all sources disabled.
  - 1 PENDING: read; write-1-to-clear.
  - 2 STATUS: read-only; bit0 = `o_active`, bits[12:8] = `o_ISR_addr`.
  - 3 SWTRIG: write-1-to-set into PENDING; reads 0.
- **Edge detect.** A line-previous register samples `i_irq_lines` every cycle. `pend_set = lines & ~lines_prev`.
- **Pending update, each edge.**
  - New value is `(PENDING & ~clr) | pend_set | swtrig_set`.
  - `clr` is the dispatch clear OR-ed with the W1C write.
  - When set and clear hit the same bit in the same cycle, set wins.
- **Arbitration.**
  - `eligible = PENDING & MASK`.
  - The winner is the lowest set index (fixed priority, 0 highest).
  - Masked pending bits stay pending and become eligible when later unmasked.
- **FSM states:** IDLE, ACTIVE, GAP. Reset enters IDLE.
- **IDLE**
  - If `eligible != 0`: go to ACTIVE, set `o_IRQ=1` and `o_active=1`, load `o_ISR_addr` with the winner, and clear the winner's pending bit.
  - Otherwise stay in IDLE.
  - `i_reti` is ignored.
- **ACTIVE**
  - Hold `o_IRQ`, `o_ISR_addr` and the vector fixed.
  - On `i_reti`: go to GAP, drop `o_IRQ` and `o_active` to 0.
  - New edges still latch into PENDING.
- **GAP**
  - Unconditional, one cycle, then IDLE.
  - This guarantees `o_IRQ` is low for at least one cycle, so the controller sees a fresh rising edge for back-to-back interrupts.
- **Vector hold.** `o_ISR_addr` keeps its last value after return. Its reset value is 0.
- **Reset values:** `o_IRQ=0`, `o_active=0`, `o_ISR_addr=0`, MASK=0, PENDING=0, lines_prev=0, state IDLE.
- **Reset mid-service.** A reset during ACTIVE drops `o_IRQ` at that edge and discards all pending bits.
- **Config write during dispatch.** A config write in the same cycle as dispatch is honoured. A MASK write takes effect from the next arbitration.

## Timing
- **Dispatch latency.** A line rises and is sampled high at edge k (low at k-1), so PENDING sets at edge k. With the source enabled and the FSM in IDLE, `o_IRQ` rises at edge k+1. That is 2 edges from line to request.
- **Return.** `i_reti` sampled at edge m causes `o_IRQ` to fall at m and the FSM to enter GAP. IDLE is reached at m+1, and the earliest next `o_IRQ` rise is edge m+2.
- **SWTRIG latency.** A SWTRIG write at edge k gives `o_IRQ` at edge k+1 if the source is eligible and the FSM is idle.
- **Read path.** `o_cfg_rdata` is zero-latency combinational.

## Structure
- **Package `vic_pkg`:**
  - `VEC_W=5`, `MAX_IRQ=32`.
  - Register address constants `VIC_REG_MASK/PENDING/STATUS/SWTRIG`.
  - FSM state encoding (IDLE, ACTIVE, GAP).
- **Sub-module `vic_prio_enc`:** combinational priority encoder. It takes a NUM_IRQ-bit vector and produces the lowest set index (5 bits) plus a `valid` flag.

## Test plan
- **Basic dispatch.** Reset, write MASK=0xFF, pulse line 3 high. Expect `o_IRQ` rising 2 edges later, `o_ISR_addr=3`, PENDING bit 3 = 0. Pulse `i_reti`: `o_IRQ` low next edge, STATUS bit0 = 0.
- **Priority.** With MASK=0xFF, raise lines 5 and 2 in the same cycle. Expect dispatch of vector 2. After `i_reti` plus GAP, expect vector 5, with `o_IRQ` low for exactly 2 cycles between the two requests.
- **Masking.** With MASK=0x01, raise line 4. Expect no `o_IRQ` and PENDING=0x10. Write MASK=0x10: expect `o_IRQ` with vector 4 on the following edge.
- **Level hold and software paths.**
  - Hold line 1 high for 10 cycles: it is dispatched once only.
  - SWTRIG write 0x80 with MASK=0xFF gives vector 7.
  - Writing PENDING 0x80 before dispatch cancels it.
- **Boundaries.**
  - An edge on line 0 in the same cycle as its own dispatch clear leaves PENDING bit 0 set.
  - `rst` asserted during ACTIVE gives `o_IRQ=0`, PENDING=0, MASK=0 on that edge.
  - `i_reti` in IDLE causes no change.
